io_controller: RTL
==================

// Module: io_controller
// PURPOSE
//  Sequencer for the IN/OUT peripheral datapath. It stalls the CPU on an IN until the user confirms with a push-button.
//  It pulses the datapath's input/output load flags and converts the sign-magnitude result to BCD for the 7-segment
//  driver with a serial double-dabble (shift-add-3) unit. It sits between control unit, IO datapath and display.
// PARAMETERS
//  DATA_W      32      datapath word width
//  SW_W        16      switch bank width (sign-extended to DATA_W)
//  DIGITS      10      BCD digits out; must satisfy 10^DIGITS > 2^(DATA_W-1)
//  DEB_CYCLES  250000  debounce stability window, clk cycles (used only with IO_DEBOUNCE_EN)
// PORTS
//  clk           in   1            system clock, all state on posedge
//  rst_n         in   1            asynchronous, active-low reset
//  in_req        in   1            IN instruction in flight; level, held while halt=1
//  out_req       in   1            OUT instruction in flight; level, held while halt=1
//  out_data      in   DATA_W       register value to display (two's complement)
//  switches      in   SW_W         user switch bank (two's complement)
//  btn_confirm   in   1            raw asynchronous confirm button, active-high
//  halt          out  1            stall CPU/PC (combinational from state and requests)
//  io_flag_input out  1            one-cycle load strobe to IO datapath (FLAG_input)
//  io_flag_output out 1            one-cycle load strobe to IO datapath (FLAG_output)
//  bcd           out  4*DIGITS     display magnitude, digit 0 = LSD
//  negative      out  1            display sign
//  disp_valid    out  1            bcd/negative hold a completed conversion
//  waiting_input out  1            lit while the FSM waits for the confirm button (user LED)
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM->IDLE; bcd=0, negative=0, disp_valid=0, flags=0; shift regs/counter cleared; sync flops=0.
//  Reset mid-operation: any state aborts to IDLE immediately, and no flag pulse is emitted.
//  FSM states: IDLE, IN_WAIT, IN_LOAD, OUT_LOAD, CONV.
//   IDLE:     in_req -> IN_WAIT; else out_req -> OUT_LOAD (in_req wins if both high).
//   IN_WAIT:  confirm edge -> IN_LOAD; otherwise stay. waiting_input=1.
//   IN_LOAD:  io_flag_input=1. Latch sign-extended switches into conv operand -> CONV.
//   OUT_LOAD: io_flag_output=1. Latch out_data into conv operand -> CONV.
//   CONV:     DATA_W iterations, one bit per cycle. After the final iteration -> IDLE.
//  Flags are decoded from the registered state only, so each is high for exactly one cycle and glitch-free.
//  halt = (IDLE & (in_req|out_req)) | IN_WAIT | (CONV & (in_req|out_req)).
//   halt is 0 in IN_LOAD/OUT_LOAD, so the CPU retires the instruction at that edge.
//   The FSM then leaves for CONV, never IDLE, so a held request cannot retrigger.
//  OUT latency: 1 stall cycle; flag at cycle 2; bcd valid DATA_W cycles later.
//  IN latency: 1 cycle after the detected edge.
//  Magnitude = op[DATA_W-1] ? (~op+1) : op, taken as unsigned DATA_W. For -2^(DATA_W-1) it is 2^(DATA_W-1),
//   which gives 2147483648 with negative=1.
//  Sign is latched at load. bcd/negative keep the previous value through CONV and update atomically on the last
//   iteration's edge, when disp_valid is set (sticky until reset).
//  Each double-dabble step adds 3 to every digit >=5, then left-shifts {bcd_work, mag} by 1.
//  Button path: 2-flop synchroniser plus rising-edge detector. An edge outside IN_WAIT is discarded. A button
//   already held when IN_WAIT is entered needs release and re-press.
// CONFIGURATION
//  IO_DEBOUNCE_EN defined: the synchronised button must stay stable for DEB_CYCLES consecutive cycles before the
//   debounced level changes. The edge detector runs on the debounced level.
//   The counter is ceil(log2(DEB_CYCLES+1)) bits and restarts on any change.
//  Not defined: the edge detector runs directly on the synchronised level, and DEB_CYCLES is ignored
//   (simulation / clean-button boards).
// STRUCTURE
//  io_ctrl_pkg: state enum (io_state_t), IDLE..CONV encodings, BCD_ADD3 threshold constant.
//   Also holds function digits_for(width) for the DIGITS legality check.
//  Sub-module bin2bcd_seq: start/operand in; busy/done/bcd out.
//   It owns the shift registers and the iteration counter (ceil(log2(DATA_W+1)) bits).
//   The FSM, synchroniser and debouncer stay in io_controller.
// TESTING
//  1 Reset: rst_n=0 during CONV -> next cycle IDLE, bcd=0, disp_valid=0, no flag pulse, halt=0 with no request.
//  2 OUT: out_data=32'd1234, out_req held -> halt=1 one cycle; io_flag_output one pulse;
//     32 cycles later bcd=...0001_0010_0011_0100, negative=0.
//  3 OUT extreme: out_data=32'h8000_0000 -> bcd=2147483648, negative=1.
//     out_data=32'hFFFF_FFFF -> bcd=1, negative=1.
//  4 IN: switches=16'hFFF6, in_req held, no press for 100 cycles -> halt=1, waiting_input=1, no flag.
//     Press -> io_flag_input one pulse, halt drops, bcd=10, negative=1.
//  5 Stray and simultaneous events: press in IDLE, then in_req with the button still held -> remains in IN_WAIT until
//     release/re-press. in_req & out_req together -> IN path taken.
//  6 Back-to-back: out_req asserted during CONV -> halt=1 until CONV ends, then normal OUT sequence.
//     With IO_DEBOUNCE_EN and DEB_CYCLES=8, 3-cycle glitches -> no edge; a 9-cycle press -> one edge.

Source files
------------

// File: rtl/io_ctrl_pkg.sv
// Shared types and constants for the IN/OUT sequencer and its serial binary-to-BCD converter.
package io_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    IN_WAIT  = 3'd1,
    IN_LOAD  = 3'd2,
    OUT_LOAD = 3'd3,
    CONV     = 3'd4
  } io_state_t;

  localparam logic [3:0] BCD_ADD3 = 4'd5;

  // Smallest digit count D with 10^D > 2^(width-1), i.e. enough for any magnitude.
  function automatic int digits_for(input int width);
    longint unsigned lim;
    longint unsigned pw;
    int d;
    lim = 64'd1 << (width - 1);
    pw  = 64'd1;
    d   = 0;
    for (int i = 0; i < 20; i++) begin
      if (pw <= lim) begin
        pw = pw * 64'd10;
        d  = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble converter: one shift-add-3 step per cycle, DATA_W steps per conversion.
module bin2bcd_seq
  import io_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     operand,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mag_q, mag_d;
  logic [4*DIGITS-1:0] work_q, work_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [4*DIGITS-1:0] adj;

  always_comb begin
    adj = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= BCD_ADD3) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
  end

  // Down-counter: terminal count 1 marks the final step.
  assign busy = (cnt_q != '0);
  assign done = (cnt_q == CNT_W'(1));
  assign bcd  = bcd_q;

  always_comb begin
    cnt_d  = cnt_q;
    mag_d  = mag_q;
    work_d = work_q;
    bcd_d  = bcd_q;
    if (start) begin
      cnt_d  = CNT_LOAD;
      mag_d  = operand;
      work_d = '0;
    end else if (busy) begin
      cnt_d           = cnt_q - CNT_W'(1);
      {work_d, mag_d} = {adj[4*DIGITS-2:0], mag_q, 1'b0};
      if (done) bcd_d = {adj[4*DIGITS-2:0], mag_q[DATA_W-1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      mag_q  <= '0;
      work_q <= '0;
      bcd_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      mag_q  <= mag_d;
      work_q <= work_d;
      bcd_q  <= bcd_d;
    end
  end

endmodule

// File: rtl/io_controller.sv
// IN/OUT sequencer: stalls the CPU for IN until a confirm press, strobes IO load flags, drives BCD display.
// Optional button debouncer enabled by defining IO_DEBOUNCE_EN.
//
// state    | meaning
// IDLE     | no IO in progress
// IN_WAIT  | IN requested, waiting for confirm button rising edge
// IN_LOAD  | pulse io_flag_input, latch sign-extended switches
// OUT_LOAD | pulse io_flag_output, latch out_data
// CONV     | BCD conversion running, display keeps previous value
module io_controller
  import io_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SW_W       = 16,
  parameter int DIGITS     = 10,
  parameter int DEB_CYCLES = 250000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_req,
  input  logic                out_req,
  input  logic [DATA_W-1:0]   out_data,
  input  logic [SW_W-1:0]     switches,
  input  logic                btn_confirm,
  output logic                halt,
  output logic                io_flag_input,
  output logic                io_flag_output,
  output logic [4*DIGITS-1:0] bcd,
  output logic                negative,
  output logic                disp_valid,
  output logic                waiting_input
);

  if (DIGITS < digits_for(DATA_W) || DEB_CYCLES < 1 || SW_W >= DATA_W) begin : g_bad_cfg
    $error("io_controller: illegal DIGITS, DEB_CYCLES or SW_W");
  end

  io_state_t           state_q, state_d;
  logic                sync1_q, sync2_q, lvl_prev_q;
  logic                btn_lvl, btn_rise;
  logic                sign_q, sign_d;
  logic                negative_q, negative_d;
  logic                disp_valid_q, disp_valid_d;
  logic                start;
  logic [DATA_W-1:0]   op, mag;
  logic                conv_busy, conv_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      lvl_prev_q <= 1'b0;
    end else begin
      sync1_q    <= btn_confirm;
      sync2_q    <= sync1_q;
      lvl_prev_q <= btn_lvl;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int               DEB_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LOAD = DEB_W'(DEB_CYCLES - 1);

  logic             deb_q, deb_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

  // Level flips only after DEB_CYCLES consecutive cycles of disagreement.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = DEB_LOAD;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == '0) deb_d = sync2_q;
      else                 deb_cnt_d = deb_cnt_q - DEB_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign btn_lvl = deb_q;
`else
  assign btn_lvl = sync2_q;
`endif

  assign btn_rise = btn_lvl & ~lvl_prev_q;

  always_comb begin
    state_d        = state_q;
    start          = 1'b0;
    op             = out_data;
    sign_d         = sign_q;
    negative_d     = negative_q;
    disp_valid_d   = disp_valid_q;
    halt           = 1'b0;
    io_flag_input  = 1'b0;
    io_flag_output = 1'b0;
    waiting_input  = 1'b0;
    case (state_q)
      IDLE: begin
        halt = in_req | out_req;
        if (in_req)       state_d = IN_WAIT;
        else if (out_req) state_d = OUT_LOAD;
      end
      IN_WAIT: begin
        halt          = 1'b1;
        waiting_input = 1'b1;
        if (btn_rise) state_d = IN_LOAD;
      end
      IN_LOAD: begin
        io_flag_input = 1'b1;
        start         = 1'b1;
        op            = {{(DATA_W-SW_W){switches[SW_W-1]}}, switches};
        sign_d        = op[DATA_W-1];
        state_d       = CONV;
      end
      OUT_LOAD: begin
        io_flag_output = 1'b1;
        start          = 1'b1;
        sign_d         = out_data[DATA_W-1];
        state_d        = CONV;
      end
      CONV: begin
        halt = in_req | out_req;
        if (conv_done) begin
          negative_d   = sign_q;
          disp_valid_d = 1'b1;
        end
        // Falling out on !busy as well keeps the FSM from sticking if the converter is ever idle here.
        if (conv_done || !conv_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mag = op[DATA_W-1] ? (~op + DATA_W'(1)) : op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sign_q       <= 1'b0;
      negative_q   <= 1'b0;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sign_q       <= sign_d;
      negative_q   <= negative_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .operand (mag),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd     (bcd)
  );

  assign negative   = negative_q;
  assign disp_valid = disp_valid_q;

endmodule
